// File: rtl/login_pkg.sv
// Shared login definitions: FSM state encoding and the user ID table.
// The password checker indexes users with the same NUM_USERS and ordering.
package login_pkg;

    localparam int unsigned NUM_USERS   = 5;
    localparam int unsigned GUEST_INDEX = 4;
    localparam int unsigned ID_WIDTH    = 16;
    localparam int unsigned INDEX_WIDTH = 5;

    // Entry position in this table is the internal user index.
    localparam logic [ID_WIDTH-1:0] ID_TABLE [NUM_USERS] = '{
        16'h8522,  // user 0
        16'h4700,  // user 1
        16'h5928,  // user 2
        16'h2071,  // user 3
        16'hFFFF   // guest
    };

    typedef enum logic [2:0] {
        StIdle,
        StGetId,
        StLookup,
        StStartChk,
        StWaitAuth,
        StLoggedIn,
        StLocked
    } loginState_e;

endpackage

// File: rtl/id_lookup.sv
// Combinational map from a 16-bit entered ID to {valid, internal user index}.
module id_lookup
    import login_pkg::*;
(
    input  logic [ID_WIDTH-1:0]    UserId,
    output logic                   Valid,
    output logic [INDEX_WIDTH-1:0] Index
);

    // Linear match against the table; IDs are unique so at most one entry hits.
    always_comb begin
        Valid = 1'b0;
        Index = '0;
        for (int unsigned i = 0; i < NUM_USERS; i++) begin
            if (UserId == ID_TABLE[i]) begin
                Valid = 1'b1;
                Index = INDEX_WIDTH'(i);
            end
        end
    end

endmodule

// File: rtl/user_id_entry.sv
// Login front end: collects a 4-digit hex ID, maps it, kicks the password checker,
// supervises its result and enforces a lockout after repeated failures.
module user_id_entry
    import login_pkg::*;
#(
    parameter int unsigned MAX_ATTEMPTS   = 3,
    parameter int unsigned AUTH_TIMEOUT   = 50000000,
    parameter int unsigned LOCKOUT_CYCLES = 250000000
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   Start,
    input  logic                   EnterPulse,
    input  logic [3:0]             InputSwitches,
    input  logic                   Authenticated,
    input  logic                   LogOutReq,
    output logic [INDEX_WIDTH-1:0] InternalID,
    output logic                   BeginCheck,
    output logic                   LogOutPulse,
    output logic                   IdError,
    output logic                   LockedOut,
    output logic [2:0]             Attempts
);

    localparam int unsigned TIMER_MAX   = (AUTH_TIMEOUT > LOCKOUT_CYCLES) ? AUTH_TIMEOUT
                                                                          : LOCKOUT_CYCLES;
    localparam int unsigned TIMER_WIDTH = (TIMER_MAX > 1) ? $clog2(TIMER_MAX) : 1;
    localparam logic [TIMER_WIDTH-1:0] AUTH_LAST = TIMER_WIDTH'(AUTH_TIMEOUT - 1);
    localparam logic [TIMER_WIDTH-1:0] LOCK_LAST = TIMER_WIDTH'(LOCKOUT_CYCLES - 1);
    localparam logic [2:0]             MAX_ATT   = 3'(MAX_ATTEMPTS);

    loginState_e             state, stateNext;
    logic [ID_WIDTH-1:0]     idReg, idRegNext;
    logic [2:0]              digCnt, digCntNext;
    logic [TIMER_WIDTH-1:0]  timer;
    logic [2:0]              attemptsNext, attemptInc;
    logic [INDEX_WIDTH-1:0]  internalIdNext;
    logic                    logOutNext;
    logic                    idValid;
    logic [INDEX_WIDTH-1:0]  idIndex;

    id_lookup uLookup (
        .UserId (idReg),
        .Valid  (idValid),
        .Index  (idIndex)
    );

    // Saturating increment so the failure count can never wrap.
    assign attemptInc = (Attempts < MAX_ATT) ? Attempts + 3'd1 : Attempts;

    // Next-state logic and the single-cycle Moore outputs.
    always_comb begin
        stateNext      = state;
        idRegNext      = idReg;
        digCntNext     = digCnt;
        attemptsNext   = Attempts;
        internalIdNext = InternalID;
        logOutNext     = 1'b0;
        BeginCheck     = 1'b0;
        IdError        = 1'b0;
        LockedOut      = 1'b0;
        unique case (state)
            StIdle: begin
                idRegNext  = '0;
                digCntNext = '0;
                if (Start) stateNext = StGetId;
            end
            StGetId: begin
                if (EnterPulse && (digCnt < 3'd4)) begin
                    idRegNext  = {idReg[ID_WIDTH-5:0], InputSwitches};
                    digCntNext = digCnt + 3'd1;
                    if (digCnt == 3'd3) stateNext = StLookup;
                end
            end
            StLookup: begin
                if (idValid) begin
                    internalIdNext = idIndex;
                    stateNext      = StStartChk;
                end else begin
                    IdError    = 1'b1;
                    digCntNext = '0;
                    stateNext  = StGetId;
                end
            end
            StStartChk: begin
                BeginCheck = 1'b1;
                stateNext  = StWaitAuth;
            end
            StWaitAuth: begin
                // A success on the timeout cycle still counts as a login.
                if (Authenticated) begin
                    attemptsNext = '0;
                    stateNext    = StLoggedIn;
                end else if (timer == AUTH_LAST) begin
                    attemptsNext   = attemptInc;
                    logOutNext     = 1'b1;
                    internalIdNext = '0;
                    stateNext      = (attemptInc == MAX_ATT) ? StLocked : StIdle;
                end
            end
            StLoggedIn: begin
                if (LogOutReq) begin
                    logOutNext     = 1'b1;
                    internalIdNext = '0;
                    stateNext      = StIdle;
                end else if (!Authenticated) begin
                    internalIdNext = '0;
                    stateNext      = StIdle;
                end
            end
            StLocked: begin
                LockedOut = 1'b1;
                if (timer == LOCK_LAST) begin
                    attemptsNext = '0;
                    stateNext    = StIdle;
                end
            end
            default: stateNext = StIdle;
        endcase
    end

    // Shared cycle timer: zeroed on every state change, saturates instead of wrapping.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            timer <= '0;
        end else if (stateNext != state) begin
            timer <= '0;
        end else if (timer != '1) begin
            timer <= timer + 1'b1;
        end
    end

    // State and datapath registers.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state       <= StIdle;
            idReg       <= '0;
            digCnt      <= '0;
            Attempts    <= '0;
            InternalID  <= '0;
            LogOutPulse <= 1'b0;
        end else begin
            state       <= stateNext;
            idReg       <= idRegNext;
            digCnt      <= digCntNext;
            Attempts    <= attemptsNext;
            InternalID  <= internalIdNext;
            LogOutPulse <= logOutNext;
        end
    end

endmodule

// File: tb/tb_user_id_entry.sv
// Directed bench for user_id_entry with short timeouts.
module tb_user_id_entry;

    logic       Clk;
    logic       Reset;
    logic       Start;
    logic       EnterPulse;
    logic [3:0] InputSwitches;
    logic       Authenticated;
    logic       LogOutReq;
    logic [4:0] InternalID;
    logic       BeginCheck;
    logic       LogOutPulse;
    logic       IdError;
    logic       LockedOut;
    logic [2:0] Attempts;

    int nChecks = 0;
    int nFails  = 0;

    user_id_entry #(
        .MAX_ATTEMPTS   (3),
        .AUTH_TIMEOUT   (20),
        .LOCKOUT_CYCLES (30)
    ) dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .Start         (Start),
        .EnterPulse    (EnterPulse),
        .InputSwitches (InputSwitches),
        .Authenticated (Authenticated),
        .LogOutReq     (LogOutReq),
        .InternalID    (InternalID),
        .BeginCheck    (BeginCheck),
        .LogOutPulse   (LogOutPulse),
        .IdError       (IdError),
        .LockedOut     (LockedOut),
        .Attempts      (Attempts)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic [15:0] id;
        logic        valid;
        logic [4:0]  idx;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance one clock; outputs are stable 1 time unit after the edge.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic doReset();
        Reset = 1'b0; Start = 1'b0; EnterPulse = 1'b0; InputSwitches = 4'h0;
        Authenticated = 1'b0; LogOutReq = 1'b0;
        tick();
        Reset = 1'b1;
    endtask

    task automatic startEntry();
        Start = 1'b1;
        tick();
        Start = 1'b0;
    endtask

    // Four digits, MS first, one idle cycle between pulses, none after the last.
    task automatic enterId(input logic [15:0] id);
        for (int i = 0; i < 4; i++) begin
            EnterPulse    = 1'b1;
            InputSwitches = id[15-4*i -: 4];
            tick();
            EnterPulse = 1'b0;
            if (i < 3) tick();
        end
    endtask

    // Enter a valid ID and let the authentication window expire.
    task automatic runTimeout(output int n);
        startEntry();
        enterId(16'h8522);
        tick();
        tick();
        n = 0;
        while (!LogOutPulse && n < 40) begin
            tick();
            n++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int lockCnt;
        int pulses;

        vecs[0] = '{16'h8522, 1'b1, 5'd0};
        vecs[1] = '{16'h4700, 1'b1, 5'd1};
        vecs[2] = '{16'h5928, 1'b1, 5'd2};
        vecs[3] = '{16'h2071, 1'b1, 5'd3};
        vecs[4] = '{16'hFFFF, 1'b1, 5'd4};
        vecs[5] = '{16'h1234, 1'b0, 5'd0};
        vecs[6] = '{16'h8523, 1'b0, 5'd0};
        vecs[7] = '{16'h0000, 1'b0, 5'd0};

        // Reset state
        doReset();
        Reset = 1'b0;
        tick();
        check("rst InternalID", 32'(InternalID), 32'd0);
        check("rst BeginCheck", 32'(BeginCheck), 32'd0);
        check("rst LogOutPulse", 32'(LogOutPulse), 32'd0);
        check("rst IdError", 32'(IdError), 32'd0);
        check("rst LockedOut", 32'(LockedOut), 32'd0);
        check("rst Attempts", 32'(Attempts), 32'd0);
        Reset = 1'b1;

        // ID table vectors
        foreach (vecs[k]) begin
            doReset();
            startEntry();
            enterId(vecs[k].id);
            check($sformatf("vec%0d IdError", k), 32'(IdError), 32'(!vecs[k].valid));
            check($sformatf("vec%0d early BeginCheck", k), 32'(BeginCheck), 32'd0);
            tick();
            if (vecs[k].valid) begin
                check($sformatf("vec%0d BeginCheck", k), 32'(BeginCheck), 32'd1);
                check($sformatf("vec%0d InternalID", k), 32'(InternalID), 32'(vecs[k].idx));
                tick();
                check($sformatf("vec%0d BeginCheck end", k), 32'(BeginCheck), 32'd0);
            end else begin
                check($sformatf("vec%0d IdError end", k), 32'(IdError), 32'd0);
                check($sformatf("vec%0d no BeginCheck", k), 32'(BeginCheck), 32'd0);
            end
        end

        // Invalid ID returns to digit entry; retry without Start
        doReset();
        startEntry();
        enterId(16'h1234);
        check("retry IdError", 32'(IdError), 32'd1);
        tick();
        check("retry IdError end", 32'(IdError), 32'd0);
        enterId(16'h2071);
        check("retry lookup IdError", 32'(IdError), 32'd0);
        tick();
        check("retry BeginCheck", 32'(BeginCheck), 32'd1);
        check("retry InternalID", 32'(InternalID), 32'd3);

        // Login, hold, logout
        doReset();
        startEntry();
        enterId(16'h4700);
        tick();
        tick();
        repeat (10) tick();
        Authenticated = 1'b1;
        tick();
        check("login Attempts", 32'(Attempts), 32'd0);
        check("login LogOutPulse", 32'(LogOutPulse), 32'd0);
        check("login InternalID", 32'(InternalID), 32'd1);
        repeat (25) tick();
        Start = 1'b1;
        tick();
        Start = 1'b0;
        check("logged Start ignored", 32'(BeginCheck), 32'd0);
        check("logged InternalID held", 32'(InternalID), 32'd1);
        LogOutReq = 1'b1;
        tick();
        LogOutReq = 1'b0;
        check("logout LogOutPulse", 32'(LogOutPulse), 32'd1);
        check("logout InternalID", 32'(InternalID), 32'd0);
        tick();
        check("logout LogOutPulse end", 32'(LogOutPulse), 32'd0);
        Authenticated = 1'b0;

        // Authenticated drop returns to idle silently
        startEntry();
        enterId(16'hFFFF);
        tick();
        tick();
        Authenticated = 1'b1;
        tick();
        Authenticated = 1'b0;
        tick();
        check("authdrop LogOutPulse", 32'(LogOutPulse), 32'd0);
        LogOutReq = 1'b1;
        tick();
        LogOutReq = 1'b0;
        check("authdrop no logout", 32'(LogOutPulse), 32'd0);

        // Three timeouts then lockout
        doReset();
        for (int a = 1; a <= 3; a++) begin
            runTimeout(n);
            check($sformatf("timeout%0d cycles", a), 32'(n), 32'd20);
            check($sformatf("timeout%0d Attempts", a), 32'(Attempts), 32'(a));
            check($sformatf("timeout%0d LockedOut", a), 32'(LockedOut), 32'(a == 3));
            if (a < 3) begin
                tick();
                check($sformatf("timeout%0d pulse end", a), 32'(LogOutPulse), 32'd0);
            end
        end
        lockCnt = 1;
        Start = 1'b1;
        EnterPulse = 1'b1;
        tick();
        Start = 1'b0;
        EnterPulse = 1'b0;
        check("locked Start ignored", 32'(LockedOut), 32'd1);
        lockCnt = 2;
        while (LockedOut && lockCnt < 100) begin
            tick();
            if (LockedOut) lockCnt++;
        end
        check("lockout length", 32'(lockCnt), 32'd30);
        check("unlock Attempts", 32'(Attempts), 32'd0);
        startEntry();
        enterId(16'h8522);
        tick();
        check("unlock BeginCheck", 32'(BeginCheck), 32'd1);

        // Reset during WAIT_AUTH
        doReset();
        runTimeout(n);
        check("pre-reset Attempts", 32'(Attempts), 32'd1);
        startEntry();
        enterId(16'h4700);
        tick();
        check("pre-reset InternalID", 32'(InternalID), 32'd1);
        repeat (4) tick();
        Reset = 1'b0;
        tick();
        Reset = 1'b1;
        check("midrst InternalID", 32'(InternalID), 32'd0);
        check("midrst Attempts", 32'(Attempts), 32'd0);
        check("midrst BeginCheck", 32'(BeginCheck), 32'd0);
        check("midrst LogOutPulse", 32'(LogOutPulse), 32'd0);
        check("midrst LockedOut", 32'(LockedOut), 32'd0);
        check("midrst IdError", 32'(IdError), 32'd0);
        pulses = 0;
        repeat (25) begin
            tick();
            if (LogOutPulse) pulses++;
        end
        check("midrst no timeout", 32'(pulses), 32'd0);

        // Authenticated on the timeout cycle wins
        doReset();
        runTimeout(n);
        startEntry();
        enterId(16'h5928);
        tick();
        tick();
        repeat (19) tick();
        Authenticated = 1'b1;
        tick();
        check("race LogOutPulse", 32'(LogOutPulse), 32'd0);
        check("race Attempts", 32'(Attempts), 32'd0);
        check("race InternalID", 32'(InternalID), 32'd2);
        check("race LockedOut", 32'(LockedOut), 32'd0);
        LogOutReq = 1'b1;
        tick();
        LogOutReq = 1'b0;
        check("race logout pulse", 32'(LogOutPulse), 32'd1);
        Authenticated = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
